// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable little-endian data memory with valid/ready request/response,
// configurable wait states, sub-word signed/unsigned loads and alignment/range error reporting.
module data_memory_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0,
  parameter bit INIT_ZERO   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic l_we, l_uns;
  logic [ADDR_W-1:0] l_addr;
  logic [1:0] l_size;
  logic [31:0] l_wdata;
  logic [7:0] mem [DEPTH] = '{default: INIT_ZERO ? 8'h00 : 8'hxx};
  logic c_we, c_uns, err, enter_resp;
  logic [ADDR_W-1:0] c_addr, a1, a2, a3;
  logic [1:0] c_size;
  logic [31:0] c_wdata, rdata_n;
  logic [2:0] nb;
  logic [ADDR_W:0] last;
  logic [7:0] b0, b1, b2, b3;
  // With zero wait states the response is built in the acceptance cycle, straight from the request inputs
  always_comb begin
    c_we       = state == IDLE ? req_we : l_we;
    c_uns      = state == IDLE ? req_unsigned : l_uns;
    c_addr     = state == IDLE ? req_addr : l_addr;
    c_size     = state == IDLE ? req_size : l_size;
    c_wdata    = state == IDLE ? req_wdata : l_wdata;
    nb         = c_size == 2'd0 ? 3'd4 : c_size == 2'd1 ? 3'd2 : 3'd1;
    last       = {1'b0, c_addr} + (ADDR_W+1)'(nb - 3'd1);
    err        = c_size == 2'd3 || (c_size == 2'd1 && c_addr[0]) || (c_size == 2'd0 && |c_addr[1:0]) || last[ADDR_W];
    a1         = c_addr + ADDR_W'(1);
    a2         = c_addr + ADDR_W'(2);
    a3         = c_addr + ADDR_W'(3);
    b0         = mem[c_addr];
    b1         = mem[a1];
    b2         = mem[a2];
    b3         = mem[a3];
    rdata_n    = (err || c_we) ? 32'h0 :
                 c_size == 2'd2 ? {{24{~c_uns & b0[7]}}, b0} :
                 c_size == 2'd1 ? {{16{~c_uns & b1[7]}}, b1, b0} : {b3, b2, b1, b0};
    enter_resp = rst_n && ((state == IDLE && req_valid && WAIT_STATES == 0) || (state == WAIT && cnt == 4'd1));
  end
  // The array has no reset; stores land only on the edge that enters RESP
  always_ff @(posedge clk) begin
    if (enter_resp && c_we && !err) begin
      mem[c_addr] <= c_wdata[7:0];
      if (c_size != 2'd2) mem[a1] <= c_wdata[15:8];
      if (c_size == 2'd0) begin
        mem[a2] <= c_wdata[23:16];
        mem[a3] <= c_wdata[31:24];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      l_we       <= 1'b0;
      l_uns      <= 1'b0;
      l_addr     <= '0;
      l_size     <= 2'd0;
      l_wdata    <= 32'h0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          l_we      <= req_we;
          l_uns     <= req_unsigned;
          l_addr    <= req_addr;
          l_size    <= req_size;
          l_wdata   <= req_wdata;
          req_ready <= 1'b0;
          cnt       <= 4'(WAIT_STATES);
          state     <= WAIT_STATES == 0 ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_rdata <= rdata_n;
        resp_err   <= err;
      end
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: two controllers (0 and 3 wait states) driven by directed tables, corner
// sequences and random traffic, checked against a byte-array reference model.
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid[2], req_ready[2], req_we[2], req_unsigned[2];
  logic resp_valid[2], resp_ready[2], resp_err[2];
  logic [9:0] req_addr[2];
  logic [1:0] req_size[2];
  logic [31:0] req_wdata[2], resp_rdata[2];
  logic [7:0] mm [2][1024];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  data_memory_ctrl #(.ADDR_W(10), .WAIT_STATES(0), .INIT_ZERO(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));
  data_memory_ctrl #(.ADDR_W(10), .WAIT_STATES(3), .INIT_ZERO(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));
  typedef struct {
    logic        we;
    logic [9:0]  a;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t tbl[15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic model(input int d, input logic we, input logic [9:0] a, input logic [1:0] sz, input logic u,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    n  = sz == 2'd0 ? 4 : sz == 2'd1 ? 2 : 1;
    er = sz == 2'd3 || (int'(a) % n) != 0 || int'(a) + n > 1024;
    rd = 32'h0;
    if (!er) begin
      if (we) for (int i = 0; i < n; i++) mm[d][int'(a) + i] = wd[8*i +: 8];
      else begin
        for (int i = 0; i < n; i++) rd[8*i +: 8] = mm[d][int'(a) + i];
        if (!u && n < 4 && rd[8*n-1]) for (int i = n; i < 4; i++) rd[8*i +: 8] = 8'hff;
      end
    end
  endtask
  task automatic txn(input int d, input logic we, input logic [9:0] a, input logic [1:0] sz, input logic u,
                     input logic [31:0] wd, input int hold, output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    logic eer;
    int n;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_we[d] = we; req_addr[d] = a; req_size[d] = sz; req_unsigned[d] = u; req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    resp_ready[d] = 1'b0;
    @(negedge clk);
    req_valid[d] = 1'b0;
    n = 1;
    while (!resp_valid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), d == 1 ? 32'd4 : 32'd1);
    rd = resp_rdata[d];
    er = resp_err[d];
    if (!resp_valid[d]) return;
    model(d, we, a, sz, u, wd, erd, eer);
    chk("rdata", rd, erd);
    chk("err", 32'(er), 32'(eer));
    for (int h = 0; h < hold; h++) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = 10'($urandom); req_size[d] = 2'd0;
      req_wdata[d] = $urandom;
      @(negedge clk);
      chk("hold_rdata", resp_rdata[d], rd);
      chk("hold_err", 32'(resp_err[d]), 32'(er));
      chk("hold_valid", 32'(resp_valid[d]), 32'd1);
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    chk("valid_drop", 32'(resp_valid[d]), 32'd0);
    chk("ready_back", 32'(req_ready[d]), 32'd1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    logic er, we, u;
    logic [9:0] a;
    logic [1:0] sz;
    int d;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 0; req_we[k] = 0; req_unsigned[k] = 0; resp_ready[k] = 0;
      req_addr[k] = '0; req_size[k] = '0; req_wdata[k] = '0;
      for (int i = 0; i < 1024; i++) mm[k][i] = 8'h00;
    end
    tbl[0]  = '{1'b1, 10'h3FC, 2'd0, 1'b0, 32'h0a48656c, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 10'h3FC, 2'd0, 1'b0, 32'h0, 32'h0a48656c, 1'b0};
    tbl[2]  = '{1'b1, 10'h3FC, 2'd0, 1'b0, 32'h8a48656c, 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 10'h3FF, 2'd2, 1'b0, 32'h0, 32'hFFFFFF8A, 1'b0};
    tbl[4]  = '{1'b0, 10'h3FF, 2'd2, 1'b1, 32'h0, 32'h0000008A, 1'b0};
    tbl[5]  = '{1'b1, 10'h101, 2'd1, 1'b0, 32'h0000BEEF, 32'h0, 1'b1};
    tbl[6]  = '{1'b0, 10'h100, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[7]  = '{1'b1, 10'h100, 2'd1, 1'b0, 32'h1234BEEF, 32'h0, 1'b0};
    tbl[8]  = '{1'b0, 10'h100, 2'd1, 1'b1, 32'h0, 32'h0000BEEF, 1'b0};
    tbl[9]  = '{1'b0, 10'h100, 2'd1, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0};
    tbl[10] = '{1'b0, 10'h3FE, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[11] = '{1'b0, 10'h000, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[12] = '{1'b0, 10'h3FC, 2'd2, 1'b1, 32'h0, 32'h0000006C, 1'b0};
    tbl[13] = '{1'b1, 10'h200, 2'd2, 1'b0, 32'hAABBCC80, 32'h0, 1'b0};
    tbl[14] = '{1'b0, 10'h200, 2'd0, 1'b0, 32'h0, 32'h00000080, 1'b0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
      chk("rst_rdata", resp_rdata[k], 32'h0);
      chk("rst_err", 32'(resp_err[k]), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      txn(0, tbl[i].we, tbl[i].a, tbl[i].sz, tbl[i].u, tbl[i].wd, 0, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
    end
    txn(1, 1'b1, 10'h040, 2'd0, 1'b0, 32'hCAFEF00D, 0, rd, er);
    txn(1, 1'b0, 10'h040, 2'd0, 1'b0, 32'h0, 5, rd, er);
    chk("bp_rdata", rd, 32'hCAFEF00D);
    txn(1, 1'b0, 10'h042, 2'd1, 1'b0, 32'h0, 0, rd, er);
    chk("bp_next_half", rd, 32'hFFFFCAFE);
    @(negedge clk);
    req_we[1] = 1'b1; req_addr[1] = 10'h010; req_size[1] = 2'd0; req_unsigned[1] = 1'b0;
    req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("mid_in_wait_ready", 32'(req_ready[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready[1]), 32'd1);
    chk("mid_rst_resp_valid", 32'(resp_valid[1]), 32'd0);
    chk("mid_rst_rdata", resp_rdata[1], 32'h0);
    chk("mid_rst_err", 32'(resp_err[1]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1, 1'b0, 10'h010, 2'd0, 1'b0, 32'h0, 0, rd, er);
    chk("abort_no_write", rd, 32'h0);
    for (int i = 0; i < 200; i++) begin
      d  = int'($urandom_range(1, 0));
      we = 1'($urandom);
      u  = 1'($urandom);
      sz = 2'($urandom_range(3, 0));
      a  = 10'($urandom);
      if ($urandom_range(3, 0) == 0) a[9:4] = '1;
      if ($urandom_range(2, 0) != 0) begin
        if (sz == 2'd0) a[1:0] = 2'd0;
        if (sz == 2'd1) a[0] = 1'b0;
      end
      txn(d, we, a, sz, u, $urandom, int'($urandom_range(2, 0)), rd, er);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
